// File: rtl/nor_eval_pkg.sv
// rtl/nor_eval_pkg.sv - shared types, defaults and helpers for the NOR-latch evaluation blocks
package nor_eval_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_PULSE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FIN
  } stim_state_t;

  localparam int INIT_CYC_DEF = 4;

  // Counts up to the all-ones value of a w-bit field and then holds there.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for the asynchronous latch output
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nor_latch_stim_ctrl.sv
// rtl/nor_latch_stim_ctrl.sv - A/B race pulse sequencer with synchronized Q sampling and trial counters
module nor_latch_stim_ctrl
  import nor_eval_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int REP_W    = 16,
  parameter int INIT_CYC = INIT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] width_a,
  input  logic [CNT_W-1:0] width_b,
  input  logic [CNT_W-1:0] offset,
  input  logic [CNT_W-1:0] settle,
  input  logic [REP_W-1:0] reps,
  input  logic             q_in,
  output logic             drive_a,
  output logic             drive_b,
  output logic             busy,
  output logic             done,
  output logic             q_sync,
  output logic [REP_W-1:0] ones_cnt,
  output logic [REP_W-1:0] run_idx
);

  localparam int PW = CNT_W + 1;

  stim_state_t      state;
  logic [PW-1:0]    t;
  logic [CNT_W-1:0] cfg_wa, cfg_wb, cfg_off, cfg_settle;
  logic [REP_W-1:0] cfg_reps;

  logic [PW-1:0]    end_a, phase_len, t_next;
  logic             win_a0, win_b0, win_a_next, win_b_next, last_rep;
  logic [REP_W:0]   run_p1;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_in),
    .q   (q_sync)
  );

  // Extra bit keeps offset+width_a from wrapping into a short phase.
  always_comb begin
    end_a     = {1'b0, cfg_off} + {1'b0, cfg_wa};
    phase_len = {1'b0, cfg_wb};
    if (end_a > phase_len) phase_len = end_a;
    if (phase_len == '0) phase_len = {{(PW-1){1'b0}}, 1'b1};
    t_next     = t + {{(PW-1){1'b0}}, 1'b1};
    win_b0     = (cfg_wb != '0);
    win_a0     = (cfg_off == '0) && (cfg_wa != '0);
    win_b_next = (t_next < {1'b0, cfg_wb});
    win_a_next = (t_next >= {1'b0, cfg_off}) && (t_next < end_a);
    run_p1     = {1'b0, run_idx} + {{REP_W{1'b0}}, 1'b1};
    last_rep   = (run_p1 == {1'b0, cfg_reps});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      t          <= '0;
      cfg_wa     <= '0;
      cfg_wb     <= '0;
      cfg_off    <= '0;
      cfg_settle <= '0;
      cfg_reps   <= '0;
      drive_a    <= 1'b0;
      drive_b    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ones_cnt   <= '0;
      run_idx    <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= ST_IDLE;
        drive_a <= 1'b0;
        drive_b <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cfg_wa     <= width_a;
              cfg_wb     <= width_b;
              cfg_off    <= offset;
              cfg_settle <= settle;
              cfg_reps   <= reps;
              ones_cnt   <= '0;
              run_idx    <= '0;
              busy       <= 1'b1;
              t          <= '0;
              if (reps == '0) begin
                state <= ST_FIN;
                done  <= 1'b1;
              end else begin
                state   <= ST_INIT;
                drive_a <= 1'b1;
              end
            end
          end
          ST_INIT: begin
            if (t == PW'(INIT_CYC - 1)) begin
              state   <= ST_PULSE;
              t       <= '0;
              drive_a <= win_a0;
              drive_b <= win_b0;
            end else begin
              t <= t_next;
            end
          end
          ST_PULSE: begin
            if (t_next < phase_len) begin
              t       <= t_next;
              drive_a <= win_a_next;
              drive_b <= win_b_next;
            end else begin
              t       <= '0;
              drive_a <= 1'b0;
              drive_b <= 1'b0;
              state   <= (cfg_settle == '0) ? ST_SAMPLE : ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (t_next == {1'b0, cfg_settle}) begin
              t     <= '0;
              state <= ST_SAMPLE;
            end else begin
              t <= t_next;
            end
          end
          ST_SAMPLE: begin
            if (q_sync) ones_cnt <= REP_W'(sat_inc(32'(ones_cnt), REP_W));
            run_idx <= REP_W'(sat_inc(32'(run_idx), REP_W));
            t       <= '0;
            if (last_rep) begin
              state <= ST_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= ST_INIT;
              drive_a <= 1'b1;
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state   <= ST_IDLE;
            drive_a <= 1'b0;
            drive_b <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
